sa_tile_ctrl: RTL

Sequencer for one systolic-array tile built from pe_int8_dsp cells. It accepts a start command with a reduction length and clears the accumulators. It then streams K operand slices with stall support, flushes the skew pipeline, and drains the result rows over a valid/ready port. It sits between the tile's operand buffers and the result writer; the PE grid shares its enable/clear/zero controls.

---
 rtl/sa_ctrl_pkg.sv | 26 ++
 rtl/sa_step_counter.sv | 48 ++++
 rtl/sa_tile_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared definitions for the systolic-array tile controller and the blocks
// around it (PE array, result writer).
//   sa_state_e : sequencer state encoding
//   flush_cyc  : number of cycles needed to push the last operand skew
//                through a ROWS x COLS grid
// ---------------------------------------------------------------------------
package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } sa_state_e;

   // The last slice enters at the array corner and has to reach the far
   // corner: (ROWS-1) + (COLS-1) extra steps.
   function automatic int flush_cyc(input int rows, input int cols);
      return rows + cols - 2;
   endfunction

endpackage

// File: rtl/sa_step_counter.sv
// ---------------------------------------------------------------------------
// sa_step_counter
// Loadable down-counter with terminal-value flags. Load wins over enable;
// the count saturates at zero rather than wrapping.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val this cycle
//   load_val   : value to load
//   en         : decrement by one (ignored when already zero)
//   is_one     : count == 1
//   is_zero    : count == 0
// ---------------------------------------------------------------------------
module sa_step_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         is_one,
   output logic         is_zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one  = (cnt_q == W'(1));
   assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/sa_tile_ctrl.sv
// ---------------------------------------------------------------------------
// sa_tile_ctrl
// Sequencer for one systolic-array tile: clear accumulators, stream K operand
// slices (stalling on empty operand buffers), flush the skew pipeline, then
// drain ROWS result rows over a valid/ready port.
// Ports:
//   clk, rstn             : clock, synchronous active-low reset
//   start, cfg_k          : command strobe (IDLE only) and reduction length
//   busy, done            : activity flag, one-cycle completion pulse
//   in_valid, in_rd       : operand slice available / consumed
//   pe_en, pe_acc_clr,
//   pe_zero_in            : shared PE grid controls
//   drain_row, out_valid,
//   out_ready, out_last   : result row index and handshake
// All outputs decode registered state/counters, except in_rd/pe_en in FEED,
// which follow in_valid directly.
// ---------------------------------------------------------------------------
module sa_tile_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int K_BITS = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [K_BITS-1:0]       cfg_k,
   output logic                    busy,
   output logic                    done,
   input  logic                    in_valid,
   output logic                    in_rd,
   output logic                    pe_en,
   output logic                    pe_acc_clr,
   output logic                    pe_zero_in,
   output logic [$clog2(ROWS)-1:0] drain_row,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   localparam int RW        = $clog2(ROWS);
   localparam int FLUSH_CYC = flush_cyc(ROWS, COLS);
   localparam int FW        = $clog2(ROWS + COLS - 1);

   sa_state_e     state_q;
   sa_state_e     state_d;
   logic [RW-1:0] drain_row_q;
   logic [RW-1:0] drain_row_d;

   logic k_load;
   logic k_en;
   logic k_is_one;
   logic k_is_zero;
   logic f_load;
   logic f_en;
   logic f_is_one;
   logic f_is_zero;

   // Remaining operand slices; loaded when the command is accepted so later
   // cfg_k changes cannot disturb the run.
   sa_step_counter #(.W(K_BITS)) u_k_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (k_load),
      .load_val (cfg_k),
      .en       (k_en),
      .is_one   (k_is_one),
      .is_zero  (k_is_zero)
   );

   // Remaining flush cycles; loaded on the transition into FLUSH.
   sa_step_counter #(.W(FW)) u_flush_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (f_load),
      .load_val (FW'(FLUSH_CYC)),
      .en       (f_en),
      .is_one   (f_is_one),
      .is_zero  (f_is_zero)
   );

   always_comb begin
      state_d     = state_q;
      drain_row_d = '0;
      busy        = 1'b0;
      done        = 1'b0;
      in_rd       = 1'b0;
      pe_en       = 1'b0;
      pe_acc_clr  = 1'b0;
      pe_zero_in  = 1'b0;
      out_valid   = 1'b0;
      k_load      = 1'b0;
      k_en        = 1'b0;
      f_load      = 1'b0;
      f_en        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               k_load  = 1'b1;
               state_d = ST_CLEAR;
            end
         end

         ST_CLEAR: begin
            busy       = 1'b1;
            pe_acc_clr = 1'b1;
            pe_en      = 1'b1;
            // Zero-length reduction: accumulators are already the answer.
            state_d    = k_is_zero ? ST_DRAIN : ST_FEED;
         end

         ST_FEED: begin
            busy  = 1'b1;
            in_rd = in_valid;
            pe_en = in_valid;
            k_en  = in_valid;
            if (in_valid && k_is_one) begin
               f_load  = 1'b1;
               state_d = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            busy       = 1'b1;
            pe_en      = 1'b1;
            pe_zero_in = 1'b1;
            f_en       = 1'b1;
            // is_zero is unreachable in normal flow; it keeps the FSM from
            // sticking here if the counter were ever left empty.
            if (f_is_one || f_is_zero) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            busy        = 1'b1;
            out_valid   = 1'b1;
            drain_row_d = drain_row_q;
            if (out_ready) begin
               if (drain_row_q == RW'(ROWS - 1)) begin
                  drain_row_d = '0;
                  state_d     = ST_DONE;
               end else begin
                  drain_row_d = drain_row_q + RW'(1);
               end
            end
         end

         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         drain_row_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_row_q <= drain_row_d;
      end
   end

   // drain_row_q is forced to zero outside DRAIN by the next-state logic,
   // so it can be driven out directly.
   assign drain_row = drain_row_q;
   assign out_last  = (state_q == ST_DRAIN) && (drain_row_q == RW'(ROWS - 1));

endmodule
